disp_pixbuf: RTL and testbench

- Pixel buffer directly downstream of the AXI display read controller.
- Captures R-channel beats (VRAM read data) into a single-clock FIFO.
- Generates FIFOREADY back to the read controller: "room for one more full burst".
- Unpacks each word into RGB565 pixels, expands them to RGB888 and presents them to the display timing stage over a valid/ready handshake.

---
 rtl/disp_pkg.sv | 27 ++
 rtl/disp_fifo_sc.sv | 57 +++++
 rtl/disp_pixbuf.sv | 118 +++++++++++
 tb/tb_disp_pixbuf.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// Shared display-path definitions: geometry constants, RGB565 pixel type and
// the RGB565 -> RGB888 expansion used by the pixel buffer.
package disp_pkg;

  localparam int BURST_BYTES = 64;
  localparam int PIX_BYTES   = 2;
  localparam int VGA_W       = 640;
  localparam int VGA_H       = 480;

  typedef logic [15:0] pix565_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pix888_t;

  // Replicating the top bits into the new LSBs keeps full-scale 565 at 0xFF.
  function automatic pix888_t rgb565_to_888(input pix565_t p);
    pix888_t q;
    q.r = {p[15:11], p[15:13]};
    q.g = {p[10:5],  p[10:9]};
    q.b = {p[4:0],   p[4:2]};
    return q;
  endfunction

endpackage

// File: rtl/disp_fifo_sc.sv
// Single-clock FIFO with a registered (BRAM-style) read port: rd_data is
// valid on the edge after rd_en and holds until the next accepted read.
module disp_fifo_sc #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  ACLK,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  rd_en,
  output logic [DATA_W-1:0]     rd_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  assign empty = (count == '0);
  assign full  = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign wr_ok = wr_en & ~full  & ~clr;
  assign rd_ok = rd_en & ~empty & ~clr;

  // NOTE: the storage array has no reset so it maps onto block RAM; the pointers and count say which entries are live.
  always_ff @(posedge ACLK) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ACLK) begin
    if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      rd_data <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (rd_ok) begin
        rd_ptr  <= rd_ptr + DEPTH_LOG2'(1);
        rd_data <= mem[rd_ptr];
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/disp_pixbuf.sv
// Pixel buffer behind the AXI display reader: buffers R beats, throttles the
// reader with FIFOREADY and streams RGB888 pixels over valid/ready.
module disp_pixbuf
  import disp_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int DEPTH_LOG2  = 9,
  parameter int BURST_BEATS = 16
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic [DATA_W-1:0] RDATA,
  input  logic              RVALID,
  input  logic              RREADY,
  input  logic              FLUSH,
  output logic              FIFOREADY,
  output logic              PIXVALID,
  input  logic              PIXREADY,
  output logic [23:0]       PIXDATA,
  output logic              OVERFLOW
);

  localparam int DEPTH        = 1 << DEPTH_LOG2;
  localparam int CW           = DEPTH_LOG2 + 1;
  localparam int PIX_PER_WORD = DATA_W / (8 * PIX_BYTES);
  localparam int IDX_W        = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  logic              clr;
  logic              beat;
  logic              wr_en;
  logic              rd_en;
  logic [DATA_W-1:0] rd_data;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_next;
  logic [CW-1:0]     space_next;
  logic              empty;
  logic              full;

  logic              up_valid;
  logic [IDX_W-1:0]  up_idx;
  logic              up_last;
  logic              pix_take;
  pix565_t           pix_cur;

  assign clr  = ARST | FLUSH;
  assign beat = RVALID & RREADY;

  // The FIFO read register doubles as the unpacker word; up_valid/up_idx track it.
  assign pix_take = up_valid & (~PIXVALID | PIXREADY);
  assign up_last  = (up_idx == IDX_W'(PIX_PER_WORD - 1));
  assign wr_en    = beat & ~full & ~clr;
  assign rd_en    = ~empty & (~up_valid | (pix_take & up_last)) & ~clr;
  assign pix_cur  = rd_data[16*int'(up_idx) +: 16];

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_next = '0;
    if (!clr) count_next = count + CW'(wr_en) - CW'(rd_en);
    space_next = CW'(DEPTH) - count_next;
  end

  disp_fifo_sc #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .ACLK    (ACLK),
    .clr     (clr),
    .wr_en   (wr_en),
    .wr_data (RDATA),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .count   (count),
    .empty   (empty),
    .full    (full)
  );

  always_ff @(posedge ACLK) begin
    if (ARST) begin
      FIFOREADY <= 1'b0;
      OVERFLOW  <= 1'b0;
      up_valid  <= 1'b0;
      up_idx    <= '0;
      PIXVALID  <= 1'b0;
      PIXDATA   <= '0;
    end else begin
      FIFOREADY <= (space_next >= CW'(BURST_BEATS));
      if (FLUSH) begin
        OVERFLOW <= 1'b0;
        up_valid <= 1'b0;
        up_idx   <= '0;
        PIXVALID <= 1'b0;
        PIXDATA  <= '0;
      end else begin
        if (beat && full) OVERFLOW <= 1'b1;

        if (rd_en) begin
          up_valid <= 1'b1;
          up_idx   <= '0;
        end else if (pix_take) begin
          if (up_last) begin
            up_valid <= 1'b0;
            up_idx   <= '0;
          end else begin
            up_idx <= up_idx + IDX_W'(1);
          end
        end

        if (pix_take) begin
          PIXVALID <= 1'b1;
          PIXDATA  <= rgb565_to_888(pix_cur);
        end else if (PIXREADY) begin
          PIXVALID <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_disp_pixbuf.sv
// Directed bench for disp_pixbuf: streaming, FIFOREADY threshold, overflow,
// back-pressure, FLUSH and mid-stream reset, with hand-derived expectations.
module tb_disp_pixbuf;

  logic        ACLK = 1'b0;
  logic        ARST;
  logic [31:0] RDATA;
  logic        RVALID;
  logic        RREADY;
  logic        FLUSH;
  logic        FIFOREADY;
  logic        PIXVALID;
  logic        PIXREADY;
  logic [23:0] PIXDATA;
  logic        OVERFLOW;

  int checks = 0;
  int errors = 0;
  logic [23:0] got [$];

  always #5 ACLK = ~ACLK;

  disp_pixbuf dut (
    .ACLK      (ACLK),
    .ARST      (ARST),
    .RDATA     (RDATA),
    .RVALID    (RVALID),
    .RREADY    (RREADY),
    .FLUSH     (FLUSH),
    .FIFOREADY (FIFOREADY),
    .PIXVALID  (PIXVALID),
    .PIXREADY  (PIXREADY),
    .PIXDATA   (PIXDATA),
    .OVERFLOW  (OVERFLOW)
  );

  // Arithmetic form of the bit-replicating 565 -> 888 expansion.
  function automatic logic [23:0] exp888(input logic [15:0] p);
    int r5 = int'(p[15:11]);
    int g6 = int'(p[10:5]);
    int b5 = int'(p[4:0]);
    int r8 = (r5 << 3) | (r5 >> 2);
    int g8 = (g6 << 2) | (g6 >> 4);
    int b8 = (b5 << 3) | (b5 >> 2);
    return 24'((r8 << 16) | (g8 << 8) | b8);
  endfunction

  function automatic logic [31:0] word_of(input int i);
    logic [15:0] lo = 16'(i);
    return {~lo, lo};
  endfunction

  // Expected pixel k of a stream of word_of(first), word_of(first+1), ...
  function automatic logic [23:0] exp_pix(input int first, input int k);
    logic [31:0] w = word_of(first + k / 2);
    return (k % 2 == 0) ? exp888(w[15:0]) : exp888(w[31:16]);
  endfunction

  // One clock: record a pixel handshake completing at this edge, then sample 1 time unit later.
  task automatic step();
    if (PIXVALID === 1'b1 && PIXREADY === 1'b1) got.push_back(PIXDATA);
    @(posedge ACLK);
    #1;
  endtask

  task automatic idle_inputs();
    RDATA    = '0;
    RVALID   = 1'b0;
    RREADY   = 1'b1;
    FLUSH    = 1'b0;
    PIXREADY = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ARST = 1'b1;
    step();
    step();
    ARST = 1'b0;
    step();
    got.delete();
  endtask

  task automatic test_reset();
    idle_inputs();
    ARST = 1'b1;
    step();
    step();
    checks++; if (FIFOREADY !== 1'b0) begin errors++; $display("FAIL reset_fifoready got %b want 0", FIFOREADY); end
    checks++; if (PIXVALID !== 1'b0) begin errors++; $display("FAIL reset_pixvalid got %b want 0", PIXVALID); end
    checks++; if (PIXDATA !== 24'h0) begin errors++; $display("FAIL reset_pixdata got %h want 000000", PIXDATA); end
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", OVERFLOW); end
    ARST = 1'b0;
    step();
    checks++; if (FIFOREADY !== 1'b1) begin errors++; $display("FAIL reset_release_fifoready got %b want 1", FIFOREADY); end
    checks++; if (PIXVALID !== 1'b0) begin errors++; $display("FAIL reset_release_pixvalid got %b want 0", PIXVALID); end
    got.delete();
  endtask

  // One burst of 0xF800_07E0: green (0x07E0) then red (0xF800), 1 pixel/cycle.
  task automatic test_stream();
    logic        vh [35];
    logic [23:0] d2;
    int          fr_low = 0;
    do_reset();
    PIXREADY = 1'b1;
    RDATA    = 32'hF800_07E0;
    for (int s = 0; s < 35; s++) begin
      RVALID = (s < 16);
      step();
      vh[s] = PIXVALID;
      if (s == 2) d2 = PIXDATA;
      if (FIFOREADY !== 1'b1) fr_low++;
    end
    RVALID = 1'b0;
    checks++; if (vh[0] !== 1'b0 || vh[1] !== 1'b0) begin errors++; $display("FAIL stream_early_valid got %b%b want 00", vh[0], vh[1]); end
    checks++; if (vh[2] !== 1'b1) begin errors++; $display("FAIL stream_latency got %b want 1", vh[2]); end
    checks++; if (d2 !== 24'h00FF00) begin errors++; $display("FAIL stream_first_pixel got %h want 00ff00", d2); end
    checks++; if (got.size() != 32) begin errors++; $display("FAIL stream_count got %0d want 32", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== ((k % 2 == 0) ? 24'h00FF00 : 24'hFF0000)) begin
        errors++; $display("FAIL stream_pixel[%0d] got %h want %h", k, got[k], (k % 2 == 0) ? 24'h00FF00 : 24'hFF0000);
      end
    end
    checks++; if (PIXVALID !== 1'b0) begin errors++; $display("FAIL stream_drained_valid got %b want 0", PIXVALID); end
    checks++; if (fr_low != 0) begin errors++; $display("FAIL stream_fifoready_low_cycles got %0d want 0", fr_low); end
  endtask

  // With PIXREADY low one word sits in the unpacker, so after beat n (n>=2) count = n-1.
  task automatic test_fifoready();
    int fr_low = 0;
    do_reset();
    RVALID = 1'b1;
    for (int n = 1; n <= 497; n++) begin
      RDATA = word_of(n);
      step();
      if (FIFOREADY !== 1'b1) fr_low++;
    end
    checks++; if (fr_low != 0) begin errors++; $display("FAIL fifoready_below_thresh low_cycles %0d want 0", fr_low); end
    RDATA = word_of(498);
    step();
    checks++; if (FIFOREADY !== 1'b0) begin errors++; $display("FAIL fifoready_fall_at_497 got %b want 0", FIFOREADY); end
    RVALID   = 1'b0;
    PIXREADY = 1'b1;
    step();
    PIXREADY = 1'b0;
    checks++; if (FIFOREADY !== 1'b1) begin errors++; $display("FAIL fifoready_rise_at_496 got %b want 1", FIFOREADY); end
    step();
    checks++; if (FIFOREADY !== 1'b1) begin errors++; $display("FAIL fifoready_hold_496 got %b want 1", FIFOREADY); end
  endtask

  // The FIFO fills at beat 513 (one word is in the unpacker); beat 514 is the first lost.
  task automatic test_overflow();
    int n_exp = 2 * 513;
    int bad   = 0;
    do_reset();
    RVALID = 1'b1;
    for (int n = 1; n <= 513; n++) begin
      RDATA = word_of(n);
      step();
    end
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL overflow_at_full got %b want 0", OVERFLOW); end
    checks++; if (FIFOREADY !== 1'b0) begin errors++; $display("FAIL overflow_fifoready got %b want 0", FIFOREADY); end
    RDATA = word_of(514);
    step();
    checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL overflow_set got %b want 1", OVERFLOW); end
    RVALID   = 1'b0;
    PIXREADY = 1'b1;
    for (int s = 0; s < 1100 && got.size() < n_exp; s++) step();
    for (int s = 0; s < 4; s++) step();
    checks++; if (got.size() != n_exp) begin errors++; $display("FAIL overflow_drain_count got %0d want %0d", got.size(), n_exp); end
    for (int k = 0; k < got.size() && k < n_exp; k++) begin
      checks++;
      if (got[k] !== exp_pix(1, k)) begin
        errors++;
        if (bad < 8) $display("FAIL overflow_order[%0d] got %h want %h", k, got[k], exp_pix(1, k));
        bad++;
      end
    end
    checks++; if (OVERFLOW !== 1'b1) begin errors++; $display("FAIL overflow_sticky got %b want 1", OVERFLOW); end
  endtask

  // Runs straight after test_overflow, so OVERFLOW is still set going in.
  task automatic test_arst_midstream();
    int vcnt = 0;
    got.delete();
    PIXREADY = 1'b1;
    RVALID   = 1'b1;
    for (int n = 1; n <= 6; n++) begin
      RDATA = word_of(n + 100);
      step();
    end
    checks++; if (PIXVALID !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b want 1", PIXVALID); end
    ARST  = 1'b1;
    RDATA = word_of(107);
    step();
    checks++; if (FIFOREADY !== 1'b0) begin errors++; $display("FAIL arst_fifoready got %b want 0", FIFOREADY); end
    checks++; if (PIXVALID !== 1'b0) begin errors++; $display("FAIL arst_pixvalid got %b want 0", PIXVALID); end
    checks++; if (PIXDATA !== 24'h0) begin errors++; $display("FAIL arst_pixdata got %h want 000000", PIXDATA); end
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL arst_overflow got %b want 0", OVERFLOW); end
    ARST   = 1'b0;
    RVALID = 1'b0;
    step();
    checks++; if (FIFOREADY !== 1'b1) begin errors++; $display("FAIL arst_release_fifoready got %b want 1", FIFOREADY); end
    for (int s = 0; s < 5; s++) begin
      step();
      if (PIXVALID !== 1'b0) vcnt++;
    end
    checks++; if (vcnt != 0) begin errors++; $display("FAIL arst_fifo_cleared valid_cycles %0d want 0", vcnt); end
  endtask

  // PIXREADY alternates every cycle; stalled pixels must hold and none may be lost or repeated.
  task automatic test_backpressure();
    logic        v, r;
    logic [23:0] d;
    int          stall_bad = 0;
    int          stalls    = 0;
    do_reset();
    RDATA = 32'hFFFF_0000;
    for (int s = 0; s < 80 && got.size() < 16; s++) begin
      RVALID   = (s < 8);
      PIXREADY = (s % 2 == 0);
      v = PIXVALID;
      r = PIXREADY;
      d = PIXDATA;
      step();
      if (v === 1'b1 && r === 1'b0) begin
        stalls++;
        if (PIXVALID !== 1'b1 || PIXDATA !== d) stall_bad++;
      end
    end
    RVALID = 1'b0;
    PIXREADY = 1'b0;
    checks++; if (got.size() != 16) begin errors++; $display("FAIL bp_count got %0d want 16", got.size()); end
    for (int k = 0; k < got.size(); k++) begin
      checks++;
      if (got[k] !== ((k % 2 == 0) ? 24'h000000 : 24'hFFFFFF)) begin
        errors++; $display("FAIL bp_pixel[%0d] got %h want %h", k, got[k], (k % 2 == 0) ? 24'h000000 : 24'hFFFFFF);
      end
    end
    checks++; if (stalls == 0 || stall_bad != 0) begin errors++; $display("FAIL bp_hold stalls %0d bad %0d want >0 and 0", stalls, stall_bad); end
  endtask

  // FLUSH on beat 8 drops that beat and everything buffered; beats 9..16 follow normally.
  task automatic test_flush();
    do_reset();
    RVALID = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      RDATA = word_of(n);
      step();
    end
    checks++; if (PIXVALID !== 1'b1) begin errors++; $display("FAIL flush_pre_valid got %b want 1", PIXVALID); end
    FLUSH = 1'b1;
    RDATA = word_of(8);
    step();
    FLUSH = 1'b0;
    checks++; if (PIXVALID !== 1'b0) begin errors++; $display("FAIL flush_pixvalid got %b want 0", PIXVALID); end
    checks++; if (FIFOREADY !== 1'b1) begin errors++; $display("FAIL flush_fifoready got %b want 1", FIFOREADY); end
    checks++; if (OVERFLOW !== 1'b0) begin errors++; $display("FAIL flush_overflow got %b want 0", OVERFLOW); end
    checks++; if (PIXDATA !== 24'h0) begin errors++; $display("FAIL flush_pixdata got %h want 000000", PIXDATA); end
    PIXREADY = 1'b1;
    for (int n = 9; n <= 16; n++) begin
      RDATA = word_of(n);
      step();
    end
    RVALID = 1'b0;
    for (int s = 0; s < 60 && got.size() < 16; s++) step();
    step();
    checks++; if (got.size() != 16) begin errors++; $display("FAIL flush_count got %0d want 16", got.size()); end
    for (int k = 0; k < got.size() && k < 16; k++) begin
      checks++;
      if (got[k] !== exp_pix(9, k)) begin
        errors++; $display("FAIL flush_pixel[%0d] got %h want %h", k, got[k], exp_pix(9, k));
      end
    end
  endtask

  initial begin
    ARST = 1'b0;
    idle_inputs();
    test_reset();
    test_stream();
    test_fifoready();
    test_overflow();
    test_arst_midstream();
    test_backpressure();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
